// File: rtl/pipelined_controller.sv
// ---------------------------------------------------------------------------
// pipelined_controller
//   Control unit for a 5-stage MIPS pipeline. Decodes the instruction held in
//   the IF/ID register, carries the control bits through ID/EX, EX/MEM and
//   MEM/WB, inserts a one-cycle stall plus bubble on a load-use hazard, and
//   flushes IF/ID and ID/EX when the EX stage redirects the PC.
//
// Ports
//   Clk, Rst      clock (rising edge), synchronous active-high reset
//   Instruction   IF/ID instruction being decoded (ID stage)
//   Redirect      EX stage reports a taken branch/jump this cycle
//   PCWrite       0 = hold PC (load-use stall)
//   IFIDWrite     0 = hold IF/ID (load-use stall)
//   IFIDFlush     1 = load a NOP into IF/ID
//   Ex*           EX-stage controls (ALUOp, ALUSrc, Branch, JR, JAL)
//   Mem*          MEM-stage controls (MemRead, MemWrite, MemSize)
//   Wb*           WB-stage controls (RegWrite, MemtoReg, JAL, WriteReg)
// ---------------------------------------------------------------------------
module pipelined_controller #(
    parameter int ALUOP_W   = 6,
    parameter int REG_W     = 5,
    parameter int LINK_REG  = 31,
    parameter int HAZARD_EN = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [31:0]        Instruction,
    input  logic               Redirect,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               IFIDFlush,
    output logic [ALUOP_W-1:0] ExALUOp,
    output logic               ExALUSrc,
    output logic               ExBranch,
    output logic               ExJR,
    output logic               ExJAL,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         MemSize,
    output logic               WbRegWrite,
    output logic               WbMemtoReg,
    output logic               WbJAL,
    output logic [REG_W-1:0]   WbWriteReg
);

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               branch;
        logic               jr;
        logic               jal;
        logic               mem_read;
        logic               mem_write;
        logic [1:0]         mem_size;
        logic               reg_write;
        logic               memto_reg;
        logic [REG_W-1:0]   dest;
    } id_ex_t;

    typedef struct packed {
        logic               mem_read;
        logic               mem_write;
        logic [1:0]         mem_size;
        logic               reg_write;
        logic               memto_reg;
        logic               jal;
        logic [REG_W-1:0]   dest;
    } ex_mem_t;

    typedef struct packed {
        logic               reg_write;
        logic               memto_reg;
        logic               jal;
        logic [REG_W-1:0]   dest;
    } mem_wb_t;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign op           = Instruction[31:26];
    assign rs           = Instruction[25:21];
    assign rt           = Instruction[20:16];
    assign rd           = Instruction[15:11];
    assign funct        = Instruction[5:0];
    assign unused_shamt = ^Instruction[10:6];

    id_ex_t  dec;
    logic    uses_rs, uses_rt;
    id_ex_t  id_ex_d, id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;
    logic    load_use, stall;

    // Opcode low bits select the access size: x11 word, x01 half, x00 byte.
    function automatic logic [1:0] size_of(input logic [5:0] opc);
        return (opc[1:0] == 2'b11) ? 2'b00 : (opc[0] ? 2'b01 : 2'b10);
    endfunction

    // ID-stage decode
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        dec     = '0;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        case (op)
            6'b000000: begin                                   // R-type
                uses_rt       = 1'b1;
                dec.memto_reg = 1'b1;
                if (funct == 6'b001000) begin                  // jr
                    dec.branch = 1'b1;
                    dec.jr     = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.dest      = REG_W'(rd);
                end
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110: begin  // addi/andi/ori/xori
                dec.alu_op    = ALUOP_W'(op);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.memto_reg = 1'b1;
                dec.dest      = REG_W'(rt);
            end
            6'b100011, 6'b100001, 6'b100000: begin             // lw/lh/lb
                dec.alu_op    = ALUOP_W'(op);
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.mem_size  = size_of(op);
                dec.reg_write = 1'b1;
                dec.dest      = REG_W'(rt);
            end
            6'b101011, 6'b101001, 6'b101000: begin             // sw/sh/sb
                uses_rt       = 1'b1;
                dec.alu_op    = ALUOP_W'(op);
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.mem_size  = size_of(op);
            end
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                uses_rt    = (op == 6'b000100) || (op == 6'b000101);  // beq/bne compare rt
                dec.alu_op = ALUOP_W'(op);
                dec.branch = 1'b1;
            end
            6'b000010: begin                                   // j
                uses_rs    = 1'b0;
                dec.alu_op = ALUOP_W'(op);
                dec.branch = 1'b1;
            end
            6'b000011: begin                                   // jal
                uses_rs       = 1'b0;
                dec.alu_op    = ALUOP_W'(op);
                dec.branch    = 1'b1;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
                dec.dest      = REG_W'(LINK_REG);
            end
            default: ;                                         // unknown opcode: NOP
        endcase
        // Register 0 is hard-wired; a write to it must never reach WB.
        if (dec.dest == '0) dec.reg_write = 1'b0;
    end

    // Load-use hazard against the load sitting in EX. A redirect discards the
    // dependent instruction anyway, so it wins over the stall.
    always_comb begin
        load_use = (HAZARD_EN != 0) && id_ex_q.mem_read && (id_ex_q.dest != '0) &&
                   ((uses_rs && (REG_W'(rs) == id_ex_q.dest)) ||
                    (uses_rt && (REG_W'(rt) == id_ex_q.dest)));
        stall     = load_use && !Redirect && !Rst;
        PCWrite   = !stall;
        IFIDWrite = !stall;
        IFIDFlush = Redirect && !Rst;
    end

    always_comb begin
        id_ex_d  = (load_use || Redirect) ? '0 : dec;
        ex_mem_d = '{mem_read:  id_ex_q.mem_read,  mem_write: id_ex_q.mem_write,
                     mem_size:  id_ex_q.mem_size,  reg_write: id_ex_q.reg_write,
                     memto_reg: id_ex_q.memto_reg, jal:       id_ex_q.jal,
                     dest:      id_ex_q.dest};
        mem_wb_d = '{reg_write: ex_mem_q.reg_write, memto_reg: ex_mem_q.memto_reg,
                     jal:       ex_mem_q.jal,       dest:      ex_mem_q.dest};
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every stage advances from its pre-edge value.
        if (Rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign ExALUOp    = id_ex_q.alu_op;
    assign ExALUSrc   = id_ex_q.alu_src;
    assign ExBranch   = id_ex_q.branch;
    assign ExJR       = id_ex_q.jr;
    assign ExJAL      = id_ex_q.jal;
    assign MemRead    = ex_mem_q.mem_read;
    assign MemWrite   = ex_mem_q.mem_write;
    assign MemSize    = ex_mem_q.mem_size;
    assign WbRegWrite = mem_wb_q.reg_write;
    assign WbMemtoReg = mem_wb_q.memto_reg;
    assign WbJAL      = mem_wb_q.jal;
    assign WbWriteReg = mem_wb_q.dest;

endmodule

// File: tb/tb_pipelined_controller.sv
// ---------------------------------------------------------------------------
// tb_pipelined_controller
//   Directed scenarios followed by random instruction streams, all compared
//   against an instruction-level model: each instruction is decoded from the
//   ISA rules into a record, and the model pipeline is three record slots.
// ---------------------------------------------------------------------------
module tb_pipelined_controller;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] Instruction = 32'h0;
    logic        Redirect = 1'b0;
    logic        PCWrite, IFIDWrite, IFIDFlush;
    logic [5:0]  ExALUOp;
    logic        ExALUSrc, ExBranch, ExJR, ExJAL;
    logic        MemRead, MemWrite;
    logic [1:0]  MemSize;
    logic        WbRegWrite, WbMemtoReg, WbJAL;
    logic [4:0]  WbWriteReg;

    always #5 Clk = ~Clk;

    pipelined_controller dut (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .Redirect(Redirect),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .ExALUOp(ExALUOp), .ExALUSrc(ExALUSrc), .ExBranch(ExBranch), .ExJR(ExJR), .ExJAL(ExJAL),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
        .WbRegWrite(WbRegWrite), .WbMemtoReg(WbMemtoReg), .WbJAL(WbJAL), .WbWriteReg(WbWriteReg)
    );

    typedef struct packed {
        logic [5:0] aluop;
        logic       alusrc, branch, jr, jal, mread, mwrite;
        logic [1:0] msize;
        logic       regwrite, memtoreg;
        logic [4:0] dest;
    } ctl_t;

    int   total = 0;
    int   bad   = 0;
    ctl_t s_ex, s_mem, s_wb;      // instruction records in EX, MEM, WB
    ctl_t d_id;                   // record of the instruction being decoded
    logic m_haz, m_rst, m_redir;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] ADD_3    = 32'h0022_1820;  // add  $3,$1,$2
    localparam logic [31:0] LW_5     = 32'h8C25_0000;  // lw   $5,0($1)
    localparam logic [31:0] ADD_DEP  = 32'h00A2_3020;  // add  $6,$5,$2
    localparam logic [31:0] ADDI_IND = 32'h20E6_0004;  // addi $6,$7,4
    localparam logic [31:0] JAL_100  = 32'h0C00_0100;  // jal  0x100
    localparam logic [31:0] SB_2     = 32'hA022_0001;  // sb   $2,1($1)
    localparam logic [31:0] JR_31    = 32'h03E0_0008;  // jr   $31
    localparam logic [31:0] SW_DEP   = 32'hAC25_0004;  // sw   $5,4($1)
    localparam logic [31:0] J_RS5    = 32'h08A0_0000;  // j with rs bits = 5
    localparam logic [31:0] LW_0     = 32'h8C20_0000;  // lw   $0,0($1)
    localparam logic [31:0] ADD_R0   = 32'h0002_3020;  // add  $6,$0,$2

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ISA-level decode of one instruction into the record the pipeline carries.
    function automatic ctl_t ref_decode(input logic [31:0] ins);
        ctl_t c;
        logic [5:0] op;
        logic [1:0] sz;
        c  = '0;
        op = ins[31:26];
        sz = (op[1:0] == 2'b11) ? 2'd0 : (op[1:0] == 2'b01) ? 2'd1 : 2'd2;
        if (op == 6'h00) begin
            c.memtoreg = 1'b1;
            if (ins[5:0] == 6'h08) begin c.branch = 1'b1; c.jr = 1'b1; end
            else begin c.regwrite = 1'b1; c.dest = ins[15:11]; end
        end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0E}) begin
            c.aluop = op; c.alusrc = 1'b1; c.regwrite = 1'b1; c.memtoreg = 1'b1; c.dest = ins[20:16];
        end else if (op inside {6'h23, 6'h21, 6'h20}) begin
            c.aluop = op; c.alusrc = 1'b1; c.mread = 1'b1; c.msize = sz; c.regwrite = 1'b1;
            c.dest = ins[20:16];
        end else if (op inside {6'h2B, 6'h29, 6'h28}) begin
            c.aluop = op; c.alusrc = 1'b1; c.mwrite = 1'b1; c.msize = sz;
        end else if (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02}) begin
            c.aluop = op; c.branch = 1'b1;
        end else if (op == 6'h03) begin
            c.aluop = op; c.branch = 1'b1; c.jal = 1'b1; c.regwrite = 1'b1; c.dest = 5'd31;
        end
        if (c.dest == 5'd0) c.regwrite = 1'b0;
        return c;
    endfunction

    function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic [5:0] op;
        logic rs_used, rt_used;
        op      = ins[31:26];
        rs_used = !(op inside {6'h02, 6'h03});
        rt_used = op inside {6'h00, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05};
        return (rs_used && ins[25:21] == r) || (rt_used && ins[20:16] == r);
    endfunction

    // Present one instruction mid-cycle and compare every output to the model.
    task automatic drive(input logic [31:0] ins, input logic redir, input logic rst);
        @(negedge Clk);
        Instruction = ins;
        Redirect    = redir;
        Rst         = rst;
        m_rst       = rst;
        m_redir     = redir;
        d_id        = ref_decode(ins);
        m_haz       = s_ex.mread && (s_ex.dest != 5'd0) && reads_reg(ins, s_ex.dest);
        #1;
        if (!rst) begin
            check("PCWrite",    PCWrite,    !(m_haz && !redir));
            check("IFIDWrite",  IFIDWrite,  !(m_haz && !redir));
            check("IFIDFlush",  IFIDFlush,  redir);
            check("ExALUOp",    ExALUOp,    s_ex.aluop);
            check("ExALUSrc",   ExALUSrc,   s_ex.alusrc);
            check("ExBranch",   ExBranch,   s_ex.branch);
            check("ExJR",       ExJR,       s_ex.jr);
            check("ExJAL",      ExJAL,      s_ex.jal);
            check("MemRead",    MemRead,    s_mem.mread);
            check("MemWrite",   MemWrite,   s_mem.mwrite);
            check("MemSize",    MemSize,    s_mem.msize);
            check("WbRegWrite", WbRegWrite, s_wb.regwrite);
            check("WbMemtoReg", WbMemtoReg, s_wb.memtoreg);
            check("WbJAL",      WbJAL,      s_wb.jal);
            check("WbWriteReg", WbWriteReg, s_wb.dest);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        if (m_rst) begin
            s_ex = '0; s_mem = '0; s_wb = '0;
        end else begin
            s_wb  = s_mem;
            s_mem = s_ex;
            s_ex  = (m_haz || m_redir) ? '0 : d_id;
        end
    endtask

    task automatic step(input logic [31:0] ins);
        drive(ins, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        logic [31:0] cur;
        logic [5:0]  ops [20];
        ops = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h21, 6'h20, 6'h2B,
                6'h29, 6'h28, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03, 6'h3F};
        s_ex = '0; s_mem = '0; s_wb = '0;

        // Reset, then reset state
        drive(NOP, 1'b0, 1'b1); tick();
        drive(NOP, 1'b0, 1'b0);
        check("rst_pcwrite", PCWrite, 1'b1);
        check("rst_ifidwrite", IFIDWrite, 1'b1);
        check("rst_wbregwrite", WbRegWrite, 1'b0);
        tick();

        // add $3,$1,$2 flows to WB in three cycles
        step(ADD_3);
        drive(NOP, 1'b0, 1'b0); check("add_ex_aluop", ExALUOp, 6'd0); tick();
        step(NOP);
        drive(NOP, 1'b0, 1'b0);
        check("add_wb_regwrite", WbRegWrite, 1'b1);
        check("add_wb_dest", WbWriteReg, 5'd3);
        check("add_wb_memtoreg", WbMemtoReg, 1'b1);
        tick();

        // lw then dependent add: one stall cycle, bubble in EX
        step(LW_5);
        drive(ADD_DEP, 1'b0, 1'b0); check("lu_pcwrite", PCWrite, 1'b0); check("lu_ifidwrite", IFIDWrite, 1'b0); tick();
        drive(ADD_DEP, 1'b0, 1'b0); check("lu_bubble_op", ExALUOp, 6'd0); check("lu_resume", PCWrite, 1'b1); tick();
        step(NOP); step(NOP); step(NOP);

        // lw then independent addi: no stall
        step(LW_5);
        drive(ADDI_IND, 1'b0, 1'b0); check("nodep_pcwrite", PCWrite, 1'b1); tick();
        step(NOP); step(NOP);

        // lw then dependent add with a redirect: flush wins, no stall
        step(LW_5);
        drive(ADD_DEP, 1'b1, 1'b0); check("redir_flush", IFIDFlush, 1'b1); check("redir_pcwrite", PCWrite, 1'b1); tick();
        drive(NOP, 1'b0, 1'b0); check("redir_bubble", ExALUSrc, 1'b0); check("redir_mem_lw", MemRead, 1'b1); tick();
        step(NOP); step(NOP);

        // jal links to $31 and never writes memory
        step(JAL_100);
        step(NOP);
        drive(NOP, 1'b0, 1'b0); check("jal_memwrite", MemWrite, 1'b0); tick();
        drive(NOP, 1'b0, 1'b0);
        check("jal_wbjal", WbJAL, 1'b1);
        check("jal_regwrite", WbRegWrite, 1'b1);
        check("jal_dest", WbWriteReg, 5'd31);
        tick();

        // sb: byte store, no register write; jr: EX jr, no register write
        step(SB_2);
        drive(JR_31, 1'b0, 1'b0); tick();
        drive(NOP, 1'b0, 1'b0); check("sb_memwrite", MemWrite, 1'b1); check("sb_size", MemSize, 2'b10);
        check("jr_exjr", ExJR, 1'b1); tick();
        drive(NOP, 1'b0, 1'b0); check("sb_wb_regwrite", WbRegWrite, 1'b0); tick();
        drive(NOP, 1'b0, 1'b0); check("jr_wb_regwrite", WbRegWrite, 1'b0); tick();

        // Boundaries: store data hazard, j ignores rs bits, $0 load never stalls
        step(LW_5);
        drive(SW_DEP, 1'b0, 1'b0); check("sw_stall", PCWrite, 1'b0); tick();
        step(SW_DEP);
        step(LW_5);
        drive(J_RS5, 1'b0, 1'b0); check("j_nostall", PCWrite, 1'b1); tick();
        step(LW_0);
        drive(ADD_R0, 1'b0, 1'b0); check("r0_nostall", PCWrite, 1'b1); tick();
        step(NOP); step(NOP); step(NOP);

        // Reset in the middle of a stall: next cycle runs free with an empty pipe
        step(LW_5);
        drive(ADD_DEP, 1'b0, 1'b1); tick();
        drive(ADD_DEP, 1'b0, 1'b0); check("rst_stall_pcwrite", PCWrite, 1'b1); check("rst_stall_mem", MemRead, 1'b0); tick();
        step(NOP); step(NOP); step(NOP);

        // Random streams; the fetch side holds the instruction while stalled
        cur = NOP;
        for (int n = 0; n < 600; n++) begin
            logic redir, rst;
            logic [31:0] fresh;
            fresh = {ops[$urandom_range(19)], 5'($urandom_range(7)), 5'($urandom_range(7)),
                     5'($urandom_range(7)), 5'd0, ($urandom_range(3) == 0) ? 6'h08 : 6'h20};
            if (!(m_haz && !m_redir && !m_rst)) cur = fresh;
            redir = ($urandom_range(7) == 0);
            rst   = ($urandom_range(63) == 0);
            drive(cur, redir, rst);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
